// File: rtl/au_sum_eq_det_pipe.sv
// au_sum_eq_det_pipe
// Two-stage valid/ready pipeline that flags (a + b + ci) mod 2^WIDTH == k
// without forming the sum: each bit compares the carry it needs against the
// carry the lower bit would produce, so no carry chain sits in front of z.
//
// Build option: define AU_SUM_EQ_DET_CNT_EN to add the saturating match
// counter (cnt_clr_i / match_cnt_o ports).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   input transaction present
//   in_ready_o   block can accept an input (combinational from out_ready_i)
//   a_i, b_i     addends
//   ci_i         carry-in
//   k_i          compare value
//   out_valid_o  result present
//   out_ready_i  downstream accepts the result
//   z_o          1 when (a + b + ci) mod 2^WIDTH == k
//   cnt_clr_i    synchronous counter clear (counter builds only)
//   match_cnt_o  saturating count of delivered z=1 results (counter builds only)
module au_sum_eq_det_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic [WIDTH-1:0] k_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             z_o
`ifdef AU_SUM_EQ_DET_CNT_EN
  ,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] match_cnt_o
`endif
);

  // Elaboration-time parameter sanity checks
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "au_sum_eq_det_pipe: parameter WIDTH=%0d must be >= 1", WIDTH);
  end
`ifdef AU_SUM_EQ_DET_CNT_EN
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "au_sum_eq_det_pipe: parameter CNT_W=%0d must be >= 1", CNT_W);
  end
`endif

  // Per-bit carry compare: r = carry needed into bit i, t = carry out of bit i
  logic [WIDTH-1:0] req_c;
  logic [WIDTH-1:0] gen_c;
  logic [WIDTH:0]   cin_all;
  logic [WIDTH-1:0] match_c;

  assign req_c   = a_i ^ b_i ^ k_i;
  assign gen_c   = (a_i & b_i) | ((a_i | b_i) & ~k_i);
  // Bit 0 sees ci; bit i sees t[i-1]; t[WIDTH-1] falls off the top (mod 2^WIDTH)
  assign cin_all = {gen_c, ci_i};
  assign match_c = ~(req_c ^ cin_all[WIDTH-1:0]);

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_match_q, s1_match_d;
  logic             out_valid_q, out_valid_d;
  logic             z_q, z_d;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv && !rst_i;
  assign in_xfer    = in_valid_i && in_ready_o;

  // Next-state for both stages
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_match_d  = s1_match_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    if (s1_adv) begin
      s1_valid_d = in_xfer;
      if (in_xfer) s1_match_d = match_c;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) z_d = &s1_match_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_match_q  <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_match_q  <= s1_match_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign z_o         = z_q;

`ifdef AU_SUM_EQ_DET_CNT_EN
  // Saturating count of delivered matches; clear wins over a same-cycle count
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_xfer;

  assign out_xfer = out_valid_q && out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (out_xfer && z_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt_o = cnt_q;
`endif

endmodule
